// File: rtl/lram_pkg.sv
// Shared types and helpers for the byte-enable LUT RAM with clear sweeper.
package lram_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} lram_state_t;

    localparam int LANE_W = 8;

    // Per-lane write-first merge: the incoming byte wins where its enable is set.
    function automatic logic [LANE_W-1:0] merge_be(input logic [LANE_W-1:0] old_b,
                                                   input logic [LANE_W-1:0] new_b,
                                                   input logic              be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/lram_lane.sv
// One 8-bit byte lane of distributed RAM: synchronous write, asynchronous read.
module lram_lane
    import lram_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LANE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem [DEPTH];

    // No reset on the array so it still maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lram_be_clr.sv
// Dual-port LUT RAM with byte enables, optional read register and a clear sweeper.
// Define LRAM_WR_BYPASS_EN for write-first same-address reads (read-first otherwise).
module lram_be_clr
    import lram_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 16,
    parameter int                RD_REG  = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0,
    localparam int               ADDR_W  = $clog2(DEPTH),
    localparam int               NLANES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    output logic              o_busy,
    input  logic              i_wren,
    input  logic [NLANES-1:0] i_wbe,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rden,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    lram_state_t       state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              busy;
    logic              wr_in_range, rd_in_range;
    logic              wr_ok, rd_acc;
    logic [NLANES-1:0] lane_we;
    logic [ADDR_W-1:0] lane_waddr;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (i_clr) begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = '0;
        end else if (state == ST_CLEAR) begin
            if (clr_cnt == LAST_ADDR) begin
                state_nxt   = ST_RUN;
                clr_cnt_nxt = '0;
            end else begin
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            end
        end
    end

    assign busy        = (state == ST_CLEAR);
    assign o_busy      = busy;
    assign wr_in_range = ({1'b0, i_waddr} < DEPTH_V);
    assign rd_in_range = ({1'b0, i_raddr} < DEPTH_V);
    assign wr_ok       = ~busy & i_wren & wr_in_range;
    assign rd_acc      = i_rden & ~busy;

    // The sweeper owns the write port while busy; user writes are simply not routed.
    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            lane_we[k] = busy | (wr_ok & i_wbe[k]);
        end
        lane_waddr = busy ? clr_cnt : i_waddr;
        lane_wdata = busy ? CLR_VAL : i_wdata;
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        lram_lane #(
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_lane (
            .clk  (clk),
            .we   (lane_we[g]),
            .waddr(lane_waddr),
            .wdata(lane_wdata[g*LANE_W +: LANE_W]),
            .raddr(i_raddr),
            .rdata(mem_rdata[g*LANE_W +: LANE_W])
        );
    end

    always_comb begin
        rd_word = mem_rdata;
`ifdef LRAM_WR_BYPASS_EN
        if (wr_ok && (i_waddr == i_raddr)) begin
            for (int k = 0; k < NLANES; k++) begin
                rd_word[k*LANE_W +: LANE_W] = merge_be(mem_rdata[k*LANE_W +: LANE_W],
                                                       i_wdata[k*LANE_W +: LANE_W],
                                                       i_wbe[k]);
            end
        end
`endif
        if (!rd_in_range) begin
            rd_word = '0;
        end
    end

    // ---- read stage p1 (registered read) ----
    if (RD_REG != 0) begin : g_rd_reg
        logic [DATA_W-1:0] rdata_p1;
        logic              vld_p1;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rdata_p1 <= '0;
                vld_p1   <= 1'b0;
            end else begin
                vld_p1 <= rd_acc;
                if (rd_acc) begin
                    rdata_p1 <= rd_word;
                end
            end
        end

        // A read accepted alongside a clear request must not qualify during the sweep.
        assign o_rdata  = rdata_p1;
        assign o_rvalid = vld_p1 & ~busy;
    end else begin : g_rd_comb
        assign o_rdata  = busy ? CLR_VAL : rd_word;
        assign o_rvalid = rd_acc;
    end

endmodule

// File: tb/tb_lram_be_clr.sv
// Scoreboard bench for lram_be_clr: registered DEPTH=16, registered DEPTH=12, async DEPTH=16.
module tb_lram_be_clr;

`ifdef LRAM_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] C_CLR = 32'hC1C2C3C4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        a_clr, a_wren, a_rden, a_busy, a_rvalid;
    logic [3:0]  a_wbe, a_waddr, a_raddr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_clr, b_wren, b_rden, b_busy, b_rvalid;
    logic [3:0]  b_wbe, b_waddr, b_raddr;
    logic [31:0] b_wdata, b_rdata;
    logic        c_clr, c_wren, c_rden, c_busy, c_rvalid;
    logic [3:0]  c_wbe, c_waddr, c_raddr;
    logic [31:0] c_wdata, c_rdata;

    lram_be_clr #(.DATA_W(32), .DEPTH(16), .RD_REG(1), .CLR_VAL(32'h0)) u_a (
        .clk(clk), .rstn(rstn), .i_clr(a_clr), .o_busy(a_busy), .i_wren(a_wren),
        .i_wbe(a_wbe), .i_waddr(a_waddr), .i_wdata(a_wdata), .i_rden(a_rden),
        .i_raddr(a_raddr), .o_rdata(a_rdata), .o_rvalid(a_rvalid));

    lram_be_clr #(.DATA_W(32), .DEPTH(12), .RD_REG(1), .CLR_VAL(32'h0)) u_b (
        .clk(clk), .rstn(rstn), .i_clr(b_clr), .o_busy(b_busy), .i_wren(b_wren),
        .i_wbe(b_wbe), .i_waddr(b_waddr), .i_wdata(b_wdata), .i_rden(b_rden),
        .i_raddr(b_raddr), .o_rdata(b_rdata), .o_rvalid(b_rvalid));

    lram_be_clr #(.DATA_W(32), .DEPTH(16), .RD_REG(0), .CLR_VAL(C_CLR)) u_c (
        .clk(clk), .rstn(rstn), .i_clr(c_clr), .o_busy(c_busy), .i_wren(c_wren),
        .i_wbe(c_wbe), .i_waddr(c_waddr), .i_wdata(c_wdata), .i_rden(c_rden),
        .i_raddr(c_raddr), .o_rdata(c_rdata), .o_rvalid(c_rvalid));

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb_q[$];
    logic [31:0] mdl[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input int addr, input logic [31:0] d, input logic [3:0] be);
        for (int k = 0; k < 4; k++) begin
            if (be[k]) mdl[addr][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic a_write(input int addr, input logic [31:0] d, input logic [3:0] be);
        a_wren = 1'b1; a_waddr = 4'(addr); a_wdata = d; a_wbe = be;
        tick();
        a_wren = 1'b0;
        upd(addr, d, be);
    endtask

    task automatic a_read(input int addr);
        a_rden = 1'b1; a_raddr = 4'(addr);
        sb_q.push_back(mdl[addr]);
        tick();
        a_rden = 1'b0;
    endtask

    // Registered-read monitor for u_a: every qualified word must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && a_rvalid) begin
            if (sb_q.size() == 0) check("a_spurious_rvalid", 32'(a_rvalid), 32'd0);
            else                  check("a_rdata", a_rdata, sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int na, nb, nc, n;
        {a_clr, a_wren, a_rden, a_wbe, a_waddr, a_raddr, a_wdata} = '0;
        {b_clr, b_wren, b_rden, b_wbe, b_waddr, b_raddr, b_wdata} = '0;
        {c_clr, c_wren, c_wbe, c_waddr, c_raddr, c_wdata} = '0;
        c_rden = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        rstn = 1'b0;
        repeat (3) tick();

        check("a_rst_busy", 32'(a_busy), 32'd1);
        check("a_rst_rvalid", 32'(a_rvalid), 32'd0);
        check("a_rst_rdata", a_rdata, 32'd0);
        check("b_rst_busy", 32'(b_busy), 32'd1);
        check("c_rst_busy", 32'(c_busy), 32'd1);
        check("c_rst_rvalid", 32'(c_rvalid), 32'd0);
        check("c_rst_rdata", c_rdata, C_CLR);

        rstn = 1'b1;
        na = 0; nb = 0; nc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!a_busy && na == 0) na = i;
            if (!b_busy && nb == 0) nb = i;
            if (!c_busy && nc == 0) nc = i;
        end
        c_rden = 1'b0;
        check("a_sweep_len", 32'(na), 32'd16);
        check("b_sweep_len", 32'(nb), 32'd12);
        check("c_sweep_len", 32'(nc), 32'd16);

        // Registered read latency probe, then the full post-sweep read-out.
        a_rden = 1'b1; a_raddr = 4'd0; sb_q.push_back(32'd0);
        tick();
        a_rden = 1'b0;
        check("a_rvalid_lat1", 32'(a_rvalid), 32'd1);
        tick();
        check("a_rvalid_drop", 32'(a_rvalid), 32'd0);
        for (int i = 0; i < 16; i++) a_read(i);

        a_write(3, 32'hAABBCCDD, 4'hF);
        a_write(3, 32'h11223344, 4'b0101);
        a_rden = 1'b1; a_raddr = 4'd3; sb_q.push_back(32'hAA22CC44);
        tick();
        a_rden = 1'b0;

        a_wren = 1'b1; a_waddr = 4'd5; a_wdata = 32'hFFFFFFFF; a_wbe = 4'h3;
        a_rden = 1'b1; a_raddr = 4'd5;
        sb_q.push_back(BYP ? 32'h0000FFFF : 32'h00000000);
        tick();
        a_wren = 1'b0; a_rden = 1'b0;
        upd(5, 32'hFFFFFFFF, 4'h3);
        a_read(5);

        for (int i = 0; i < 24; i++) a_write($urandom_range(15), $urandom, 4'($urandom_range(15)));
        for (int i = 0; i < 8; i++) begin
            int wa, ra;
            logic [31:0] d;
            logic [3:0]  be;
            wa = $urandom_range(15);
            ra = (wa + 1 + $urandom_range(14)) % 16;
            d  = $urandom;
            be = 4'($urandom_range(15));
            a_wren = 1'b1; a_waddr = 4'(wa); a_wdata = d; a_wbe = be;
            a_rden = 1'b1; a_raddr = 4'(ra);
            sb_q.push_back(mdl[ra]);
            tick();
            upd(wa, d, be);
        end
        a_wren = 1'b0; a_rden = 1'b0;
        for (int i = 0; i < 16; i++) a_read(i);
        repeat (2) tick();
        check("a_sb_drain", 32'(sb_q.size()), 32'd0);

        // Clear restart mid-sweep with user traffic held active the whole time.
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        repeat (6) tick();
        a_clr = 1'b1;
        a_wren = 1'b1; a_waddr = 4'd9; a_wdata = 32'hDEADBEEF; a_wbe = 4'hF;
        a_rden = 1'b1; a_raddr = 4'd9;
        tick();
        a_clr = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin
            tick();
            n++;
            check("a_rvalid_busy", 32'(a_rvalid), 32'd0);
        end
        a_wren = 1'b0; a_rden = 1'b0;
        check("a_clr_restart_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        a_read(9);
        a_read(3);
        a_read(5);
        repeat (2) tick();
        check("a_sb_drain2", 32'(sb_q.size()), 32'd0);

        // DEPTH=12: out-of-range write is dropped and out-of-range read returns zero.
        b_wren = 1'b1; b_waddr = 4'd13; b_wdata = 32'hFFFFFFFF; b_wbe = 4'hF;
        tick();
        b_waddr = 4'd11; b_wdata = 32'h5A5A5A5A;
        tick();
        b_wren = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 12) continue;
            b_rden = 1'b1; b_raddr = 4'(i);
            tick();
            check("b_rdata", b_rdata, (i == 11) ? 32'h5A5A5A5A : 32'h0);
            check("b_rvalid", 32'(b_rvalid), 32'd1);
        end
        b_rden = 1'b0;

        // Async read port.
        c_rden = 1'b1; c_raddr = 4'd0;
        #2;
        check("c_clrval", c_rdata, C_CLR);
        c_rden = 1'b0;
        c_wren = 1'b1; c_waddr = 4'd7; c_wdata = 32'h12345678; c_wbe = 4'hF;
        tick();
        c_wren = 1'b0;
        c_rden = 1'b1; c_raddr = 4'd7;
        #2;
        check("c_async_rdata", c_rdata, 32'h12345678);
        check("c_async_rvalid", 32'(c_rvalid), 32'd1);
        c_rden = 1'b0;
        #1;
        check("c_rvalid_idle", 32'(c_rvalid), 32'd0);
        c_wren = 1'b1; c_waddr = 4'd2; c_wdata = 32'hFFFFFFFF; c_wbe = 4'h3;
        c_rden = 1'b1; c_raddr = 4'd2;
        #2;
        check("c_collide", c_rdata, BYP ? 32'hC1C2FFFF : C_CLR);
        tick();
        c_wren = 1'b0;
        #2;
        check("c_after_collide", c_rdata, 32'hC1C2FFFF);
        c_rden = 1'b0;

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
